// File: rtl/uart_rx_fifo_if.sv
// Receive-side register interface of uart_rx_fifo: frame configuration in,
// FIFO head, status and read/clear strobes between the receiver and the APB block.
interface uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [1:0]                    data_bit_num_i;
  logic                          parity_en_i;
  logic                          parity_type_i;
  logic                          stop_bit_num_i;
  logic                          rd_en_i;
  logic                          clr_overrun_i;
  logic [7:0]                    rx_data_o;
  logic [2:0]                    rx_err_o;
  logic                          rx_empty_o;
  logic                          rx_full_o;
  logic [$clog2(FIFO_DEPTH):0]   rx_level_o;
  logic                          overrun_o;

  modport master (
    output data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i,
           rd_en_i, clr_overrun_i,
    input  rx_data_o, rx_err_o, rx_empty_o, rx_full_o, rx_level_o, overrun_o
  );

  modport slave (
    input  data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i,
           rd_en_i, clr_overrun_i,
    output rx_data_o, rx_err_o, rx_empty_o, rx_full_o, rx_level_o, overrun_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled, majority-voted UART receiver with a first-word-fall-through
// receive FIFO, per-character error tags, overrun flag and rts_n flow control.
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_LEVEL  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_tick,
  input  logic           rx,
  uart_rx_fifo_if.slave  bus,
  output logic           rts_n
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] C_S0   = CW'(M - 1);
  localparam logic [CW-1:0] C_S1   = CW'(M);
  localparam logic [CW-1:0] C_RES  = CW'(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic            smp0, smp1;
  logic            vote, resolve, tick_end;
  logic [1:0]      cfg_bits;
  logic            cfg_par_en, cfg_par_type, cfg_stop2;
  logic [7:0]      shreg;
  logic [3:0]      bit_idx, nbits;
  logic            par_bit, stop_idx;
  logic [7:0]      data_w;
  logic            exp_par, pe, fe, brk, push;

  logic [10:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            full, empty, pop, wr, overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign resolve  = rx_tick && (cnt == C_RES);
  assign tick_end = rx_tick && (cnt == C_LAST);
  // third sample is taken live at the resolve count rather than stored
  assign vote     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign nbits    = 4'd5 + {2'b00, cfg_bits};

  always_comb begin
    case (cfg_bits)
      2'b00:   data_w = {3'b000, shreg[7:3]};
      2'b01:   data_w = {2'b00,  shreg[7:2]};
      2'b10:   data_w = {1'b0,   shreg[7:1]};
      default: data_w = shreg;
    endcase
  end

  assign exp_par = cfg_par_type ? ^data_w : ~^data_w;
  assign pe      = cfg_par_en && (par_bit != exp_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    fe        = 1'b0;
    brk       = 1'b0;
    case (state)
      IDLE:     if (!rx_s) state_nxt = START;
      START: begin
        if (resolve && vote) state_nxt = IDLE;
        else if (tick_end)   state_nxt = DATA;
      end
      DATA:     if (tick_end && bit_idx == nbits) state_nxt = cfg_par_en ? PARITY : STOP;
      PARITY:   if (tick_end) state_nxt = STOP;
      STOP: begin
        if (resolve) begin
          fe = !vote;
          if (!stop_idx) begin
            brk = (data_w == 8'h00) && !(cfg_par_en && par_bit) && !vote;
            // a low first stop bit ends the frame even when two are configured
            if (!vote || !cfg_stop2) begin
              push      = 1'b1;
              state_nxt = brk ? BRK_WAIT : IDLE;
            end
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      BRK_WAIT: if (rx_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      smp0         <= 1'b1;
      smp1         <= 1'b1;
      cfg_bits     <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= 1'b0;
      cfg_stop2    <= 1'b0;
      shreg        <= '0;
      bit_idx      <= '0;
      par_bit      <= 1'b0;
      stop_idx     <= 1'b0;
    end else begin
      if (state == IDLE)  cnt <= '0;
      else if (rx_tick)   cnt <= (cnt == C_LAST) ? '0 : cnt + CW'(1);

      if (rx_tick && cnt == C_S0) smp0 <= rx_s;
      if (rx_tick && cnt == C_S1) smp1 <= rx_s;

      if (state == IDLE && !rx_s) begin
        cfg_bits     <= bus.data_bit_num_i;
        cfg_par_en   <= bus.parity_en_i;
        cfg_par_type <= bus.parity_type_i;
        cfg_stop2    <= bus.stop_bit_num_i;
        par_bit      <= 1'b0;
      end

      if (state == START && tick_end) begin
        shreg   <= '0;
        bit_idx <= '0;
      end

      if (state == DATA && resolve) begin
        shreg   <= {vote, shreg[7:1]};
        bit_idx <= bit_idx + 4'd1;
      end

      if (state == PARITY && resolve) par_bit <= vote;

      if ((state == DATA || state == PARITY) && state_nxt == STOP) stop_idx <= 1'b0;
      else if (state == STOP && resolve)                           stop_idx <= 1'b1;
    end
  end

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign pop   = bus.rd_en_i && !empty;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {brk, fe, pe, data_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
      rts_n   <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push && full && !pop)   overrun <= 1'b1;
      else if (bus.clr_overrun_i) overrun <= 1'b0;
      rts_n <= (level >= LW'(RTS_LEVEL));
    end
  end

  assign bus.rx_data_o  = empty ? '0 : mem[rd_ptr][7:0];
  assign bus.rx_err_o   = empty ? '0 : mem[rd_ptr][10:8];
  assign bus.rx_empty_o = empty;
  assign bus.rx_full_o  = full;
  assign bus.rx_level_o = level;
  assign bus.overrun_o  = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: frame formats, errors, break,
// FIFO fill/overrun/flow control, glitch rejection and mid-frame reset.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tick_ph = 1'b0;
  logic rx_tick;
  logic rts_n;

  int n_checks = 0;
  int n_errs   = 0;

  uart_rx_fifo_if #(.FIFO_DEPTH(16)) bus_if ();

  uart_rx_fifo #(
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16),
    .RTS_LEVEL (12)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_tick(rx_tick),
    .rx     (rx),
    .bus    (bus_if),
    .rts_n  (rts_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick_ph <= ~tick_ph;
  assign rx_tick = tick_ph;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!rx_tick) @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx = b;
    wait_ticks(n);
  endtask

  // gl selects a data bit that gets a one-tick inverted pulse near its middle
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input logic stop2, input logic s2val,
                            input int gl);
    send_bit(1'b0, 16);
    for (int i = 0; i < nb; i++) begin
      if (i == gl) begin
        send_bit(d[i], 9);
        send_bit(~d[i], 1);
        send_bit(d[i], 6);
      end else begin
        send_bit(d[i], 16);
      end
    end
    if (pen) send_bit(pbit, 16);
    send_bit(1'b1, 16);
    if (stop2) send_bit(s2val, 16);
    send_bit(1'b1, 4);
  endtask

  task automatic pop();
    bus_if.rd_en_i = 1'b1;
    @(negedge clk);
    bus_if.rd_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] nb, input logic pen, input logic ptype,
                         input logic stop2);
    bus_if.data_bit_num_i = nb;
    bus_if.parity_en_i    = pen;
    bus_if.parity_type_i  = ptype;
    bus_if.stop_bit_num_i = stop2;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    bus_if.rd_en_i       = 1'b0;
    bus_if.clr_overrun_i = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_empty",   32'(bus_if.rx_empty_o), 32'd1);
    check("rst_full",    32'(bus_if.rx_full_o),  32'd0);
    check("rst_level",   32'(bus_if.rx_level_o), 32'd0);
    check("rst_overrun", 32'(bus_if.overrun_o),  32'd0);
    check("rst_rts",     32'(rts_n),             32'd0);
    check("rst_data",    32'(bus_if.rx_data_o),  32'd0);
    check("rst_err",     32'(bus_if.rx_err_o),   32'd0);

    // 8N1 0xA5
    wait_ticks(8);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check("t1_level", 32'(bus_if.rx_level_o), 32'd1);
    check("t1_data",  32'(bus_if.rx_data_o),  32'hA5);
    check("t1_err",   32'(bus_if.rx_err_o),   32'd0);
    pop();
    check("t1_empty", 32'(bus_if.rx_empty_o), 32'd1);

    // 7E1 0x35: even parity bit is 0
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    check("t2a_data", 32'(bus_if.rx_data_o), 32'h35);
    check("t2a_err",  32'(bus_if.rx_err_o),  32'b001);
    pop();
    send_frame(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    check("t2b_data", 32'(bus_if.rx_data_o), 32'h35);
    check("t2b_err",  32'(bus_if.rx_err_o),  32'b000);
    pop();

    // 8N2 with a low second stop bit
    set_cfg(2'b11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    wait_ticks(40);
    check("t3_level", 32'(bus_if.rx_level_o), 32'd1);
    check("t3_data",  32'(bus_if.rx_data_o),  32'h3C);
    check("t3_err",   32'(bus_if.rx_err_o),   32'b010);
    pop();

    // break: line low for two frame times
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 320);
    check("t4_level_low", 32'(bus_if.rx_level_o), 32'd1);
    send_bit(1'b1, 40);
    check("t4_level", 32'(bus_if.rx_level_o), 32'd1);
    check("t4_data",  32'(bus_if.rx_data_o),  32'h00);
    check("t4_err",   32'(bus_if.rx_err_o),   32'b110);
    pop();
    check("t4_empty", 32'(bus_if.rx_empty_o), 32'd1);

    // fill: 17 frames, no pops
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h40 + i), 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      if (i == 10) check("t5_rts_11", 32'(rts_n), 32'd0);
      if (i == 11) check("t5_rts_12", 32'(rts_n), 32'd1);
      if (i == 15) begin
        check("t5_full_16",    32'(bus_if.rx_full_o), 32'd1);
        check("t5_overrun_16", 32'(bus_if.overrun_o), 32'd0);
      end
    end
    check("t5_full",    32'(bus_if.rx_full_o),  32'd1);
    check("t5_overrun", 32'(bus_if.overrun_o),  32'd1);
    check("t5_level",   32'(bus_if.rx_level_o), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5_pop%0d", i), 32'(bus_if.rx_data_o), 32'(8'h40 + i));
      pop();
    end
    check("t5_empty",       32'(bus_if.rx_empty_o), 32'd1);
    check("t5_rts_drained", 32'(rts_n),             32'd0);
    check("t5_ovr_kept",    32'(bus_if.overrun_o),  32'd1);
    bus_if.clr_overrun_i = 1'b1;
    @(negedge clk);
    bus_if.clr_overrun_i = 1'b0;
    @(negedge clk);
    check("t5_ovr_clr", 32'(bus_if.overrun_o), 32'd0);

    // 3-tick start glitch
    send_bit(1'b0, 3);
    send_bit(1'b1, 40);
    check("t6_glitch_start", 32'(bus_if.rx_level_o), 32'd0);

    // one-tick glitch in data bit 3 of 0x5A
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    check("t6_glitch_level", 32'(bus_if.rx_level_o), 32'd1);
    check("t6_glitch_data",  32'(bus_if.rx_data_o),  32'h5A);
    check("t6_glitch_err",   32'(bus_if.rx_err_o),   32'b000);

    // reset mid-frame with one entry still in the FIFO
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 8);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check("t6_rst_level", 32'(bus_if.rx_level_o), 32'd0);
    check("t6_rst_empty", 32'(bus_if.rx_empty_o), 32'd1);
    check("t6_rst_data",  32'(bus_if.rx_data_o),  32'd0);
    check("t6_rst_rts",   32'(rts_n),             32'd0);
    rst_n = 1'b1;
    send_bit(1'b1, 40);
    check("t6_post_rst_idle", 32'(bus_if.rx_level_o), 32'd0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    check("t6_post_level", 32'(bus_if.rx_level_o), 32'd1);
    check("t6_post_data",  32'(bus_if.rx_data_o),  32'hC3);
    check("t6_post_err",   32'(bus_if.rx_err_o),   32'b000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
